// File: rtl/grf_pkg.sv
// Shared defaults and word/address types for the general register file.
package grf_pkg;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;

    typedef logic [GRF_ADDR_W-1:0] reg_addr_t;
    typedef logic [GRF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/grf_rd_port.sv
// One combinational read port: zero-register masking, write-through bypass
// from both write ports (port 0 first), and busy reporting for stall logic.
module grf_rd_port
    import grf_pkg::*;
#(
    parameter int DATA_W   = GRF_DATA_W,
    parameter int ADDR_W   = GRF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] stored,
    input  logic              busy,
    output logic [DATA_W-1:0] rd,
    output logic              rd_busy
);

    logic hit0;
    logic hit1;
    logic is_zero;

    // Priority select: hardwired zero, then wp0 bypass, then wp1 bypass, then storage.
    always_comb begin
        hit0    = we0 && (wa0 == ra);
        hit1    = we1 && (wa1 == ra);
        is_zero = (ZERO_REG != 0) && (ra == '0);
        rd      = stored;
        if (is_zero)
            rd = '0;
        else if (hit0)
            rd = wd0;
        else if (hit1)
            rd = wd1;
        // A pending write to this address satisfies the reservation this cycle.
        rd_busy = busy && !hit0 && !hit1 && !is_zero;
    end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with two write ports, bypassing read
// ports and a per-register busy scoreboard.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DATA_W   = GRF_DATA_W,
    parameter int ADDR_W   = GRF_ADDR_W,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic              wr0_ok;
    logic              wr1_ok;

    // Register 0 swallows writes when it is hardwired to zero.
    assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Storage update; wp1 is written first so a same-address wp0 write overrides it.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++)
                regs_reg[i] <= '0;
        end else begin
            if (wr1_ok)
                regs_reg[wa1] <= wd1;
            if (wr0_ok)
                regs_reg[wa0] <= wd0;
        end
    end

    // Per-register scoreboard: flush beats reserve, reserve beats release.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
            assign busy_next[gi] = flush                                     ? 1'b0 :
                                   (rsv_en && (rsv_addr == IDX) && !IS_ZERO) ? 1'b1 :
                                   ((we0 && (wa0 == IDX)) ||
                                    (we1 && (wa1 == IDX)))                   ? 1'b0 :
                                                                               busy_reg[gi];
        end
    endgenerate

    // Scoreboard register.
    always_ff @(posedge clk or posedge res) begin
        if (res)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    // Read ports; outputs are held at zero while reset is asserted, even if a
    // write port would otherwise forward.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] port_ra;
            logic [DATA_W-1:0] port_rd;
            logic              port_busy;

            assign port_ra = ra[gi*ADDR_W +: ADDR_W];

            grf_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .ra      (port_ra),
                .we0     (we0),
                .wa0     (wa0),
                .wd0     (wd0),
                .we1     (we1),
                .wa1     (wa1),
                .wd1     (wd1),
                .stored  (regs_reg[port_ra]),
                .busy    (busy_reg[port_ra]),
                .rd      (port_rd),
                .rd_busy (port_busy)
            );

            assign rd[gi*DATA_W +: DATA_W] = res ? '0 : port_rd;
            assign rd_busy[gi]             = res ? 1'b0 : port_busy;
        end
    endgenerate

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: two instances (hardwired zero register and ordinary
// register 0) share all stimulus; outputs are compared against hand-computed
// vectors and an array-based reference model.
module tb_grf_mp;
    import grf_pkg::*;

    logic        clk;
    logic        res;
    logic [14:0] ra;
    logic [95:0] rd_z;
    logic [95:0] rd_n;
    logic [2:0]  bsy_z;
    logic [2:0]  bsy_n;
    logic        we0;
    reg_addr_t   wa0;
    reg_data_t   wd0;
    logic        we1;
    reg_addr_t   wa1;
    reg_data_t   wd1;
    logic        rsv_en;
    reg_addr_t   rsv_addr;
    logic        flush;

    int tests;
    int fails;

    // Reference state: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
    reg_data_t m_reg  [2][32];
    bit        m_busy [2][32];

    typedef struct {
        logic      we0;
        reg_addr_t wa0;
        reg_data_t wd0;
        logic      we1;
        reg_addr_t wa1;
        reg_data_t wd1;
        logic      rsv_en;
        reg_addr_t rsv_addr;
        logic      flush;
        reg_addr_t ra0;
        reg_addr_t ra1;
        reg_addr_t ra2;
        reg_data_t e0;
        reg_data_t e1;
        reg_data_t e2;
        logic [2:0] eb;
        reg_data_t enz0;
    } vec_t;

    vec_t tbl [22];

    grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)) dut (
        .clk(clk), .res(res), .ra(ra), .rd(rd_z), .rd_busy(bsy_z),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) dut_nz (
        .clk(clk), .res(res), .ra(ra), .rd(rd_n), .rd_busy(bsy_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic reg_data_t m_rd(input int d, input reg_addr_t a);
        if (d == 0 && a == 5'd0) return '0;
        if (we0 && wa0 == a) return wd0;
        if (we1 && wa1 == a) return wd1;
        return m_reg[d][a];
    endfunction

    function automatic logic m_bsy(input int d, input reg_addr_t a);
        if (d == 0 && a == 5'd0) return 1'b0;
        if ((we0 && wa0 == a) || (we1 && wa1 == a)) return 1'b0;
        return m_busy[d][a];
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                m_reg[d][r]  = '0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    // Effect of one rising edge on the reference state.
    task automatic m_clock();
        for (int d = 0; d < 2; d++) begin
            if (we1 && !(d == 0 && wa1 == 5'd0)) m_reg[d][wa1] = wd1;
            if (we0 && !(d == 0 && wa0 == 5'd0)) m_reg[d][wa0] = wd0;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[d][r] = 1'b0;
            end else begin
                if (we0) m_busy[d][wa0] = 1'b0;
                if (we1) m_busy[d][wa1] = 1'b0;
                if (rsv_en && !(d == 0 && rsv_addr == 5'd0)) m_busy[d][rsv_addr] = 1'b1;
            end
        end
    endtask

    // Compare every read port of both instances with the model.
    task automatic chk_model(input string tag);
        reg_addr_t a;
        for (int p = 0; p < 3; p++) begin
            a = ra[p*5 +: 5];
            chk($sformatf("%s z rd%0d", tag, p), rd_z[p*32 +: 32], m_rd(0, a));
            chk($sformatf("%s z busy%0d", tag, p), {31'd0, bsy_z[p]}, {31'd0, m_bsy(0, a)});
            chk($sformatf("%s nz rd%0d", tag, p), rd_n[p*32 +: 32], m_rd(1, a));
            chk($sformatf("%s nz busy%0d", tag, p), {31'd0, bsy_n[p]}, {31'd0, m_bsy(1, a)});
        end
    endtask

    task automatic idle_inputs();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0;
    endtask

    initial begin
        vec_t v;
        tests = 0;
        fails = 0;
        res = 1'b1;
        ra = '0;
        idle_inputs();
        m_reset();

        //      we0 wa0 wd0            we1 wa1 wd1       rsv ra  fl ra0 ra1 ra2 e0            e1     e2     eb      enz0
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    0, 0,  0, 5,  0,  0,  32'hDEADBEEF, 0,     0,     3'b000, 32'hDEADBEEF};
        tbl[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 5,  0,  0,  32'hDEADBEEF, 0,     0,     3'b000, 32'hDEADBEEF};
        tbl[2]  = '{1, 7, 32'h11,       1, 7, 32'h22,   0, 0,  0, 0,  7,  7,  32'h0,        32'h11,32'h11,3'b000, 32'h0};
        tbl[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 5,  7,  7,  32'hDEADBEEF, 32'h11,32'h11,3'b000, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 32'h0,        1, 0, 32'hFFFF, 0, 0,  0, 0,  0,  0,  32'h0,        0,     0,     3'b000, 32'hFFFF};
        tbl[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 0,  0,  0,  32'h0,        0,     0,     3'b000, 32'hFFFF};
        tbl[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 9,  0, 9,  0,  0,  32'h0,        0,     0,     3'b000, 32'h0};
        tbl[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 9,  0,  0,  32'h0,        0,     0,     3'b001, 32'h0};
        tbl[8]  = '{0, 0, 32'h0,        1, 9, 32'h99,   0, 0,  0, 9,  0,  0,  32'h99,       0,     0,     3'b000, 32'h99};
        tbl[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 9,  0,  0,  32'h99,       0,     0,     3'b000, 32'h99};
        tbl[10] = '{1, 9, 32'hAA,       0, 0, 32'h0,    1, 9,  0, 9,  0,  0,  32'hAA,       0,     0,     3'b000, 32'hAA};
        tbl[11] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 9,  0,  0,  32'hAA,       0,     0,     3'b001, 32'hAA};
        tbl[12] = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 3,  0, 3,  4,  6,  32'h0,        0,     0,     3'b000, 32'h0};
        tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 4,  0, 3,  4,  6,  32'h0,        0,     0,     3'b001, 32'h0};
        tbl[14] = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 6,  1, 3,  4,  6,  32'h0,        0,     0,     3'b011, 32'h0};
        tbl[15] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 3,  4,  6,  32'h0,        0,     0,     3'b000, 32'h0};
        tbl[16] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 9,  0,  0,  32'hAA,       0,     0,     3'b000, 32'hAA};
        tbl[17] = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 0,  0, 0,  0,  0,  32'h0,        0,     0,     3'b000, 32'hFFFF};
        tbl[18] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 0,  0,  0,  32'h0,        0,     0,     3'b000, 32'hFFFF};
        tbl[19] = '{0, 5, 32'h1234,     0, 0, 32'h0,    0, 0,  0, 5,  0,  0,  32'hDEADBEEF, 0,     0,     3'b000, 32'hDEADBEEF};
        tbl[20] = '{1, 31, 32'hCAFE,    0, 0, 32'h0,    0, 0,  0, 31, 0,  0,  32'hCAFE,     0,     0,     3'b000, 32'hCAFE};
        tbl[21] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0,  0, 30, 31, 0,  32'h0,        32'hCAFE,0,   3'b000, 32'h0};

        // Leave initial reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        res = 1'b0;

        // Load a value and a reservation so the reset has something to clear.
        we0 = 1; wa0 = 5'd5; wd0 = 32'h55; rsv_en = 1; rsv_addr = 5'd5;
        @(posedge clk);
        m_clock();
        @(negedge clk);
        idle_inputs();
        ra = {5'd0, 5'd0, 5'd5};
        #1;
        chk("preload rd0", rd_z[31:0], 32'h55);
        chk("preload busy0", {31'd0, bsy_z[0]}, 32'd1);
        $display("[TB] preload reg5=0x55 busy");

        // Mid-cycle reset with a pending write: outputs drop at once, write is lost.
        we0 = 1; wa0 = 5'd5; wd0 = 32'h77;
        #1 res = 1'b1;
        #1;
        chk("reset held rd0", rd_z[31:0], 32'h0);
        chk("reset held busy0", {31'd0, bsy_z[0]}, 32'd0);
        chk("reset held nz rd0", rd_n[31:0], 32'h0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        res = 1'b0;
        m_reset();
        #1;
        chk("post reset rd0", rd_z[31:0], 32'h0);
        chk("post reset busy0", {31'd0, bsy_z[0]}, 32'd0);
        $display("[TB] mid-cycle reset applied and released");

        // Every address reads zero and not busy after reset.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ra = {5'(a), 5'(a), 5'(a)};
            #1;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("rst z rd a%0d p%0d", a, p), rd_z[p*32 +: 32], 32'h0);
                chk($sformatf("rst nz rd a%0d p%0d", a, p), rd_n[p*32 +: 32], 32'h0);
            end
            chk($sformatf("rst busy a%0d", a), {26'd0, bsy_n, bsy_z}, 32'h0);
            $display("[TB] reset read addr %0d", a);
        end

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            v = tbl[i];
            @(negedge clk);
            we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
            we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
            rsv_en = v.rsv_en; rsv_addr = v.rsv_addr; flush = v.flush;
            ra = {v.ra2, v.ra1, v.ra0};
            #1;
            chk($sformatf("vec%0d rd0", i), rd_z[31:0], v.e0);
            chk($sformatf("vec%0d rd1", i), rd_z[63:32], v.e1);
            chk($sformatf("vec%0d rd2", i), rd_z[95:64], v.e2);
            chk($sformatf("vec%0d busy", i), {29'd0, bsy_z}, {29'd0, v.eb});
            chk($sformatf("vec%0d nz rd0", i), rd_n[31:0], v.enz0);
            chk_model($sformatf("vec%0d", i));
            $display("[TB] vec %0d ra=%0d/%0d/%0d rd0=%h busy=%b", i, v.ra0, v.ra1, v.ra2, rd_z[31:0], bsy_z);
            @(posedge clk);
            m_clock();
        end

        // Randomised traffic on a narrow address range to force collisions.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            #1;
            chk_model($sformatf("rnd%0d", i));
            $display("[TB] rnd %0d ra=%h rd_z=%h busy_z=%b busy_nz=%b", i, ra, rd_z, bsy_z, bsy_n);
            @(posedge clk);
            m_clock();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
